gcd_controller: RTL
===================

// Module: gcd_controller
// PURPOSE
//   Moore/Mealy FSM that sequences the 16-bit subtractive GCD datapath (A/B regs, operand muxes, subtractor, comparator).
//   Loads operand A then B from data_in, then runs one subtract per cycle until A==B; the result is left in register A.
//   Provides a start/busy/done handshake to the host and a watchdog that aborts non-terminating runs (a zero operand).
// PARAMETERS
//   MAX_ITER  65535  max subtract cycles before abort (1..2^CNT_W-1)
//   CNT_W     16     width of the iteration counter
// PORTS
//   clk      in   1      single clock, rising edge
//   rst      in   1      asynchronous, active-high reset
//   start    in   1      begin a run; sampled only in IDLE
//   gt       in   1      datapath comparator: A > B
//   lt       in   1      datapath comparator: A < B
//   eq       in   1      datapath comparator: A == B
//   ldA      out  1      load register A from bus
//   ldB      out  1      load register B from bus
//   sel1     out  1      subtractor minuend mux: 0=A, 1=B
//   sel2     out  1      subtractor subtrahend mux: 0=A, 1=B
//   sel_in   out  1      bus mux: 0=subtractor out, 1=data_in
//   req_a    out  1      host must drive operand A on data_in this cycle
//   req_b    out  1      host must drive operand B on data_in this cycle
//   busy     out  1      run in progress (LD_A, LD_B, CALC)
//   done     out  1      one-cycle pulse: GCD valid in A
//   err      out  1      watchdog abort; sticky until next accepted start
// BEHAVIOUR
//   States: IDLE, LD_A, LD_B, CALC, DONE, ERR. State register and iter counter reset asynchronously on rst.
//   Reset: state=IDLE, counter=0, err=0; all outputs 0 (sel1/sel2/sel_in=0). rst mid-run aborts at once, no done/err.
//   IDLE: start=1 -> LD_A, clear counter and err; start=0 -> stay. start outside IDLE is ignored (no queueing).
//   LD_A: sel_in=1, ldA=1, req_a=1, busy=1 -> LD_B.   LD_B: sel_in=1, ldB=1, req_b=1, busy=1 -> CALC.
//   CALC (busy=1, sel_in=0); outputs are combinational on gt/lt/eq (Mealy), decisions in priority order:
//     eq                 -> DONE, no load.
//     counter==MAX_ITER  -> ERR, no load.
//     gt                 -> sel1=0, sel2=1, ldA=1 (A<=A-B), counter+1, stay.
//     lt                 -> sel1=1, sel2=0, ldB=1 (B<=B-A), counter+1, stay.
//     no flag set (illegal) -> ERR.
//   DONE: done=1 for one cycle -> IDLE unconditionally; start in the DONE cycle is ignored.
//   ERR: err=1 -> IDLE next cycle; err stays 1 in IDLE until the next accepted start.
//   ldA and ldB are never asserted together. In CALC, exactly one of ldA/ldB is high per subtract cycle.
//   Latency: start sampled at edge 0 -> LD_A cycle 1, LD_B cycle 2, CALC cycles 3..3+N, done in cycle N+4 (N = subtracts).
//   Counter saturates at MAX_ITER and never wraps. Counter value is retained after DONE/ERR until the next start.
// CONFIGURATION
//   GCD_ITER_CNT_EN defined: extra port iter_cnt (out, CNT_W) = live subtract count, reset 0, held after DONE/ERR.
//   GCD_ITER_CNT_EN undefined: iter_cnt port absent; internal watchdog counter and all other behaviour unchanged.
// TESTING
//   A=12,B=8, start pulse -> gt then lt subtracts, done=1 in cycle 6, A reg=4, err=0 (iter_cnt=2 if enabled).
//   A=7,B=7 -> no loads in CALC, done=1 in cycle 4, A reg=7 (iter_cnt=0).
//   A=1,B=65535, MAX_ITER=65535 -> 65534 ldB subtracts, done in cycle 65538, A=1, err=0.
//   A=0,B=5, MAX_ITER=8 -> 8 ldB cycles, ERR in cycle 12, err=1 held in IDLE, cleared on next start.
//   start held high through DONE -> exactly one run plus a new run from IDLE; start pulses while busy -> ignored.
//   rst asserted mid-CALC between edges -> outputs 0 immediately, state IDLE; later start runs normally.

Source files
------------

// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - sequencer for a 16-bit subtractive GCD datapath with start/busy/done handshake and watchdog
// Optional feature macro: GCD_ITER_CNT_EN (exposes the live subtract count on iter_cnt).
module gcd_controller #(
  parameter int MAX_ITER = 65535,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic             ldA,
  output logic             ldB,
  output logic             sel1,
  output logic             sel2,
  output logic             sel_in,
  output logic             req_a,
  output logic             req_b,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [CNT_W-1:0] iter_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, LD_A, LD_B, CALC, DONE, ERR} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LD_A;
            cnt   <= '0;
            err_q <= 1'b0;
          end
        end
        LD_A: state <= LD_B;
        LD_B: state <= CALC;
        CALC: begin
          // eq wins over the watchdog so a run finishing on its last allowed cycle still completes
          if (eq) begin
            state <= DONE;
          end else if (cnt == MAX_CNT) begin
            state <= ERR;
            err_q <= 1'b1;
          end else if (gt || lt) begin
            cnt <= cnt + 1'b1;
          end else begin
            state <= ERR;
            err_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ldA    = 1'b0;
    ldB    = 1'b0;
    sel1   = 1'b0;
    sel2   = 1'b0;
    sel_in = 1'b0;
    req_a  = 1'b0;
    req_b  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      LD_A: begin
        sel_in = 1'b1;
        ldA    = 1'b1;
        req_a  = 1'b1;
        busy   = 1'b1;
      end
      LD_B: begin
        sel_in = 1'b1;
        ldB    = 1'b1;
        req_b  = 1'b1;
        busy   = 1'b1;
      end
      CALC: begin
        busy = 1'b1;
        if (!eq && cnt != MAX_CNT) begin
          if (gt) begin
            sel2 = 1'b1;
            ldA  = 1'b1;
          end else if (lt) begin
            sel1 = 1'b1;
            ldB  = 1'b1;
          end
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign err = err_q;

`ifdef GCD_ITER_CNT_EN
  assign iter_cnt = cnt;
`endif

endmodule
